// File: rtl/retire_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : retire_trace_pkg
//  Description : Shared types for the retirement trace unit: record kinds,
//                the trace record layout, state encodings and the commit
//                classifier. Optional macro RETIRE_TRACE_CYCLE_EN adds a
//                32-bit cycle stamp to every record.
//  Revision    : 1.0 - initial release
// ============================================================================
package retire_trace_pkg;

    typedef enum logic [2:0] {
        REG   = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        NOP   = 3'd3,
        HALT  = 3'd4
    } trace_kind_t;

    // Record body; the instruction number travels beside it because its
    // width is a parameter of the top module.
    typedef struct packed {
`ifdef RETIRE_TRACE_CYCLE_EN
        logic [31:0] cycle;
`endif
        trace_kind_t kind;
        logic [15:0] pc;
        logic [3:0]  dst;
        logic [15:0] value;
        logic [15:0] addr;
    } trace_rec_t;

    localparam int          c_STATE_W   = 2;
    localparam logic [1:0]  c_ST_RUN    = 2'd0;
    localparam logic [1:0]  c_ST_HALTED = 2'd1;
    localparam logic [1:0]  c_ST_DONE   = 2'd2;

    // Build a record from the commit signals; fields unused by the chosen
    // kind stay zero. The cycle stamp is filled in by the caller.
    function automatic trace_rec_t classify(
        input logic [15:0] pc,
        input logic        regWrite,
        input logic [3:0]  writeReg,
        input logic [15:0] writeData,
        input logic        memRead,
        input logic        memWrite,
        input logic [15:0] memAddr,
        input logic [15:0] memData,
        input logic        hlt
    );
        trace_rec_t rec;
        rec    = '0;
        rec.pc = pc;
        if (regWrite && memRead) begin
            rec.kind  = LOAD;
            rec.dst   = writeReg;
            rec.value = writeData;
            rec.addr  = memAddr;
        end else if (regWrite) begin
            rec.kind  = REG;
            rec.dst   = writeReg;
            rec.value = writeData;
        end else if (hlt) begin
            rec.kind  = HALT;
        end else if (memWrite) begin
            rec.kind  = STORE;
            rec.value = memData;
            rec.addr  = memAddr;
        end else begin
            rec.kind  = NOP;
        end
        return rec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/retire_trace_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Synchronous FIFO with registered full flag. A push while
//                full is accepted only when a pop happens in the same cycle.
//                The read word is zero whenever the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_full
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE  = 1;
    localparam logic [c_AW:0]   c_CNT_ONE  = 1;
    localparam logic [c_AW:0]   c_CNT_FULL = DEPTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wrPtr;
    logic [c_AW-1:0]  r_rdPtr;
    logic [c_AW:0]    r_count;
    logic             r_full;
    logic             w_doPush;
    logic             w_doPop;
    logic [c_AW:0]    w_countNext;

    assign o_valid  = (r_count != '0);
    assign o_full   = r_full;
    assign w_doPop  = i_pop & o_valid;
    assign w_doPush = i_push & (~r_full | w_doPop);
    assign o_rdata  = o_valid ? r_mem[r_rdPtr] : '0;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_countNext = r_count;
        case ({w_doPush, w_doPop})
            2'b10:   w_countNext = r_count + c_CNT_ONE;
            2'b01:   w_countNext = r_count - c_CNT_ONE;
            default: w_countNext = r_count;
        endcase
    end

    // Storage array; contents need no reset because empty reads return zero.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + c_PTR_ONE;
            if (w_doPop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
            r_count <= w_countNext;
            r_full  <= (w_countNext == c_CNT_FULL);
        end
    end

endmodule
`default_nettype wire

// File: rtl/retire_trace_unit.sv
`default_nettype none
// ============================================================================
//  Module      : retire_trace_unit
//  Description : Turns per-cycle retirement signals into numbered, typed
//                trace records, buffers them in trace_fifo and drains them
//                over a valid/ready stream. Optional macro
//                RETIRE_TRACE_CYCLE_EN adds the out_cycle stamp port.
//  Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_unit
    import retire_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int INUM_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [15:0]       commit_pc,
    input  logic              reg_write,
    input  logic [3:0]        write_reg,
    input  logic [15:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              hlt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [INUM_W-1:0] out_inum,
    output logic [15:0]       out_pc,
    output logic [3:0]        out_reg,
    output logic [15:0]       out_value,
    output logic [15:0]       out_addr,
`ifdef RETIRE_TRACE_CYCLE_EN
    output logic [31:0]       out_cycle,
`endif
    output logic              full,
    output logic              overflow,
    output logic              done
);

    localparam int                c_WORD_W   = INUM_W + $bits(trace_rec_t);
    localparam logic [INUM_W-1:0] c_INUM_ONE = 1;

    logic [c_STATE_W-1:0] r_state;
    logic [INUM_W-1:0]    r_inum;
    logic                 r_overflow;
    trace_rec_t           w_rec;
    trace_rec_t           w_headRec;
    logic [INUM_W-1:0]    w_headInum;
    logic [c_WORD_W-1:0]  w_headWord;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

`ifdef RETIRE_TRACE_CYCLE_EN
    logic [31:0] r_cycle;

    // Free-running cycle count stamped into each record at commit.
    always_ff @(posedge clk) begin
        if (rst) r_cycle <= '0;
        else     r_cycle <= r_cycle + 32'd1;
    end

    // Classify the commit and attach the cycle stamp.
    always_comb begin
        w_rec = classify(commit_pc, reg_write, write_reg, write_data,
                         mem_read, mem_write, mem_addr, mem_data, hlt);
        w_rec.cycle = r_cycle;
    end

    assign out_cycle = w_headRec.cycle;
`else
    // Classify the commit.
    always_comb begin
        w_rec = classify(commit_pc, reg_write, write_reg, write_data,
                         mem_read, mem_write, mem_addr, mem_data, hlt);
    end
`endif

    // Commits count only while running; a commit that finds the FIFO full
    // with no pop is dropped but still consumes an instruction number.
    assign w_accept = commit_valid & (r_state == c_ST_RUN);
    assign w_pop    = out_valid & out_ready;
    assign w_push   = w_accept & (~full | w_pop);
    assign w_drop   = w_accept & full & ~w_pop;

    trace_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({r_inum, w_rec}),
        .i_pop   (w_pop),
        .o_rdata (w_headWord),
        .o_valid (out_valid),
        .o_full  (full)
    );

    assign {w_headInum, w_headRec} = w_headWord;
    assign out_kind  = w_headRec.kind;
    assign out_inum  = w_headInum;
    assign out_pc    = w_headRec.pc;
    assign out_reg   = w_headRec.dst;
    assign out_value = w_headRec.value;
    assign out_addr  = w_headRec.addr;
    assign overflow  = r_overflow;
    assign done      = (r_state == c_ST_DONE);

    // Instruction numbering, halt sequencing and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_inum     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_inum <= r_inum + c_INUM_ONE;
            if (w_drop)   r_overflow <= 1'b1;
            case (r_state)
                c_ST_RUN: begin
                    if (w_push && (w_rec.kind == HALT)) r_state <= c_ST_HALTED;
                end
                c_ST_HALTED: begin
                    if (w_pop && (w_headRec.kind == HALT)) r_state <= c_ST_DONE;
                end
                default: r_state <= c_ST_DONE;
            endcase
        end
    end

endmodule
`default_nettype wire
